// File: rtl/memarb_pkg.sv
// Shared encodings for mem_arbiter: FSM states, grant owner, full-strobe constant
// and the byte-lane merge used by the read-modify-write path.
package memarb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;

    // Lanes with a set strobe take the new byte; the rest keep the old byte.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin arbiter: rr_last remembers the last accepted grant and
// only advances when the grant is actually taken by the FSM.
module rr_arbiter_2
    import memarb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic accept,
    output gnt_t gnt,
    output gnt_t rr_last
);

    // D wins a tie unless it was the last one served.
    always_comb begin
        gnt = GNT_I;
        if (req_d && (!req_i || rr_last == GNT_I)) begin
            gnt = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= GNT_I;
        end else if (accept) begin
            rr_last <= gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported negedge-sampled memory between fetch (I) and data (D)
// requesters; sub-word stores become read-modify-write. Optional: MEMARB_BOUNDS_CHECK_EN.
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    if (MEM_BYTES < 4) begin : g_mem_bytes_invalid
        $error("mem_arbiter: MEM_BYTES must hold at least one word");
    end

    state_t            state;
    state_t            next_state;
    gnt_t              gnt;
    gnt_t              owner;
    logic              accept;
    logic              oob;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic              unused_low_bits;

    assign accept   = (state == S_IDLE) && (i_req || d_req);
    assign sel_addr = (gnt == GNT_I) ? i_addr : d_addr;

    // Byte offset within the word is meaningless for word-aligned accesses.
    assign unused_low_bits = ^sel_addr[1:0];

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_i   (i_req),
        .req_d   (d_req),
        .accept  (accept),
        .gnt     (gnt),
        .rr_last (owner)
    );

`ifdef MEMARB_BOUNDS_CHECK_EN
    logic err_q;

    assign oob = ({sel_addr[ADDR_W-1:2], 2'b11} >= ADDR_W'(MEM_BYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= oob;
        end
    end

    assign i_err = i_ack && err_q;
    assign d_err = d_ack && err_q;
`else
    assign oob   = 1'b0;
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (oob) begin
                        next_state = S_DONE;
                    end else if (gnt == GNT_I || !d_we) begin
                        next_state = S_RD;
                    end else if (d_wstrb == WSTRB_FULL) begin
                        next_state = S_WR;
                    end else if (d_wstrb == 4'b0000) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                mem_en     = 1'b1;
                next_state = S_DONE;
            end
            S_RMW_RD: begin
                mem_en     = 1'b1;
                next_state = S_MERGE;
            end
            S_MERGE: begin
                next_state = S_WR;
            end
            S_WR: begin
                mem_en     = 1'b1;
                mem_rw     = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Latched request, merged write word and per-port read results.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= sel_addr[ADDR_W-1:2];
                        if (gnt == GNT_D) begin
                            wstrb_q <= d_wstrb;
                            wdata_q <= d_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (owner == GNT_I) begin
                        i_rdata <= mem_rdata;
                    end else begin
                        d_rdata <= mem_rdata;
                    end
                end
                S_MERGE: begin
                    wdata_q <= merge_lanes(old_q, wdata_q, wstrb_q);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RMW_RD) begin
            old_q <= mem_rdata;
        end
    end

    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign i_ack     = (state == S_DONE) && (owner == GNT_I);
    assign d_ack     = (state == S_DONE) && (owner == GNT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a word-array reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;

    logic [31:0] chip [32];
    logic [31:0] ref_mem [32];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory chip: acts on the negedge following the posedge that set its inputs.
    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt++;
            if (mem_rw) chip[mem_addr[6:2]] = mem_wdata;
            else        mem_rdata = chip[mem_addr[6:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {26'b0, mem_en, mem_rw, i_ack, d_ack, i_err, d_err}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_d(input string name, input logic we, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        d_we = we; d_wstrb = strb; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (d_ack) got = 1'b1;
        end
        check({name, "_ack"}, {31'b0, got}, 32'd1);
        rdata = d_rdata;
        err   = d_err;
        d_req = 1'b0;
        @(posedge clk); #1;
        check({name, "_ack_pulse"}, {31'b0, d_ack}, 32'd0);
    endtask

    task automatic do_i(input string name, input logic [31:0] addr,
                        output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        i_addr = addr; i_req = 1'b1;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (i_ack) got = 1'b1;
        end
        check({name, "_ack"}, {31'b0, got}, 32'd1);
        rdata = i_rdata;
        err   = i_err;
        i_req = 1'b0;
        @(posedge clk); #1;
        check({name, "_ack_pulse"}, {31'b0, i_ack}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_en;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] r;
        logic [31:0] last_d;
        logic        e;
        int          l;
        int          en0;
        int          n;
        int          cyc;
        logic        model_last_d;
        logic        d_raise;
        logic        i_raise;
        logic        ack_seen;

        vecs[0] = '{1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h00000000, 2, 1};
        vecs[1] = '{1'b0, 4'b0000, 32'h10, 32'h0,        32'hDEADBEEF, 2, 1};
        vecs[2] = '{1'b1, 4'b1111, 32'h20, 32'h11223344, 32'hDEADBEEF, 2, 1};
        vecs[3] = '{1'b1, 4'b0010, 32'h20, 32'h0000AA00, 32'hDEADBEEF, 4, 2};
        vecs[4] = '{1'b0, 4'b0000, 32'h20, 32'h0,        32'h1122AA44, 2, 1};
        vecs[5] = '{1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h1122AA44, 1, 0};
        vecs[6] = '{1'b0, 4'b0000, 32'h22, 32'h0,        32'h1122AA44, 2, 1};
        vecs[7] = '{1'b1, 4'b1001, 32'h20, 32'hCAFEF00D, 32'h1122AA44, 4, 2};
        vecs[8] = '{1'b0, 4'b0000, 32'h20, 32'h0,        32'hCA22AA0D, 2, 1};

        for (int w = 0; w < 32; w++) chip[w] = 32'h0;
        mem_rdata = 32'h0;
        i_addr = '0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            en0 = en_cnt;
            do_d($sformatf("vec%0d", i), vecs[i].we, vecs[i].strb, vecs[i].addr,
                 vecs[i].wdata, r, e, l);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            check($sformatf("vec%0d_lat", i), l, vecs[i].exp_lat);
            check($sformatf("vec%0d_en", i), en_cnt - en0, vecs[i].exp_en);
            check($sformatf("vec%0d_err", i), {31'b0, e}, 32'd0);
        end

        // Fetch from an unaligned address reads the containing word
        i_addr = 32'h13; i_req = 1'b1;
        @(posedge clk); #1;
        check("fetch13_mem_addr", mem_addr, 32'h10);
        check("fetch13_rd_ctrl", {30'b0, mem_en, mem_rw}, 32'd2);
        @(posedge clk); #1;
        check("fetch13_ack", {31'b0, i_ack}, 32'd1);
        check("fetch13_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
        @(posedge clk); #1;

        // Both requesters held from reset and re-requesting: grants must alternate
        reset = 1'b1;
        i_addr = 32'h20; d_addr = 32'h10; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_last_d = 1'b0;
        d_raise = 1'b0; i_raise = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (d_raise) begin d_req = 1'b1; d_raise = 1'b0; end
            if (i_raise) begin i_req = 1'b1; i_raise = 1'b0; end
            if (d_ack || i_ack) begin
                check($sformatf("rr_grant%0d", n), {31'b0, d_ack}, {31'b0, !model_last_d});
                model_last_d = !model_last_d;
                n++;
                if (d_ack) begin d_req = 1'b0; d_raise = 1'b1; end
                if (i_ack) begin i_req = 1'b0; i_raise = 1'b1; end
            end
        end
        check("rr_count", n, 4);

        // Reset during MERGE of a partial store must leave memory untouched
        do_reset();
        do_d("pre_rmw", 1'b1, 4'b1111, 32'h0, 32'h55667788, r, e, l);
        d_we = 1'b1; d_wstrb = 4'b0001; d_addr = 32'h0; d_wdata = 32'h000000FF; d_req = 1'b1;
        @(posedge clk); #1;
        check("abort_rmw_rd_en", {31'b0, mem_en}, 32'd1);
        ack_seen = 1'b0;
        @(posedge clk); #1;
        check("abort_merge_en", {31'b0, mem_en}, 32'd0);
        reset = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        ack_seen = ack_seen | d_ack | i_ack;
        check_all_zero("abort");
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | d_ack | i_ack;
        end
        check("abort_no_ack", {31'b0, ack_seen}, 32'd0);
        check("abort_chip_word", chip[0], 32'h55667788);
        do_d("abort_readback", 1'b0, 4'b0000, 32'h0, 32'h0, r, e, l);
        check("abort_readback_rdata", r, 32'h55667788);

        // Address just past the end of the chip
        en0 = en_cnt;
        do_d("oob", 1'b0, 4'b0000, 32'h80, 32'h0, r, e, l);
`ifdef MEMARB_BOUNDS_CHECK_EN
        check("oob_err", {31'b0, e}, 32'd1);
        check("oob_lat", l, 1);
        check("oob_en", en_cnt - en0, 0);
        check("oob_rdata_kept", r, 32'h55667788);
`else
        check("oob_err", {31'b0, e}, 32'd0);
        check("oob_lat", l, 2);
        check("oob_en", en_cnt - en0, 1);
`endif

        // Randomized traffic against the word-array model
        for (int w = 0; w < 32; w++) begin
            ref_mem[w] = $urandom;
            do_d("rinit", 1'b1, 4'b1111, w * 4, ref_mem[w], r, e, l);
        end
        do_d("rinit_ld", 1'b0, 4'b0000, 32'h0, 32'h0, r, e, l);
        check("rinit_ld_rdata", r, ref_mem[0]);
        last_d = ref_mem[0];
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  st;
            int          kind;
            int          exp_lat;
            a    = $urandom_range(0, 127);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_i("rfetch", a, r, e, l);
                check($sformatf("rfetch%0d_rdata", t), r, ref_mem[a / 4]);
                check($sformatf("rfetch%0d_lat", t), l, 2);
            end else if (kind == 1) begin
                do_d("rload", 1'b0, 4'b0000, a, 32'h0, r, e, l);
                check($sformatf("rload%0d_rdata", t), r, ref_mem[a / 4]);
                check($sformatf("rload%0d_lat", t), l, 2);
                last_d = ref_mem[a / 4];
            end else begin
                st = 4'($urandom_range(0, 15));
                wd = $urandom;
                do_d("rstore", 1'b1, st, a, wd, r, e, l);
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) ref_mem[a / 4][8*b +: 8] = wd[8*b +: 8];
                end
                exp_lat = (st == 4'b0000) ? 1 : (st == 4'b1111) ? 2 : 4;
                check($sformatf("rstore%0d_lat", t), l, exp_lat);
                check($sformatf("rstore%0d_rdata_kept", t), r, last_d);
            end
        end
        for (int w = 0; w < 32; w++) begin
            check($sformatf("rfinal_word%0d", w), chip[w], ref_mem[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported, byte-addressed, negedge-clocked memory chip and shares it between two requesters: instruction fetch (I, read-only) and data load/store (D).
- Round-robin arbitration between I and D.
- Word-aligned accesses only.
- Sub-word stores are handled by a read-modify-write sequence, because the chip only writes full words.
- Sits between the core's fetch/LSU stages and the memory chip.

Parameters:
- ADDR_W, 32, width of all address ports.
- MEM_BYTES, 128, chip capacity in bytes; used only by the optional bounds check.

Ports:
- clk  in  1  system clock; FSM runs on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_ack  out  1  one-cycle completion pulse for I.
- i_rdata  out  32  fetched word; valid while i_ack.
- i_err  out  1  I address fault; valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_wstrb  in  4  byte-lane strobes for stores.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, lane-aligned.
- d_ack  out  1  one-cycle completion pulse for D.
- d_rdata  out  32  load word; valid while d_ack.
- d_err  out  1  D address fault; valid with d_ack.
- mem_en  out  1  chip enable.
- mem_rw  out  1  0=read, 1=write.
- mem_addr  out  ADDR_W  chip address, bits [1:0] forced to 0.
- mem_wdata  out  32  chip write data.
- mem_rdata  in  32  chip read data.

Behaviour:
- Reset (sync, active-high): FSM=IDLE, rr_last=I (so D wins the first tie).
  - All outputs 0: mem_en, mem_rw, mem_addr, mem_wdata, i_ack, d_ack, i_rdata, d_rdata, i_err, d_err.
  - Reset mid-operation aborts the access; no ack is issued and the requester must re-request.
  - A store aborted between RMW_RD and WR leaves memory unmodified.
- Chip timing: the chip samples on negedge. Signals registered at posedge E0 are acted on at the following negedge, and mem_rdata is valid at posedge E1.
- FSM states: IDLE, RD, RMW_RD, MERGE, WR, DONE.
  - IDLE: if any req is high, grant per round-robin and latch the address (plus we/wstrb/wdata for D); update rr_last.
    - I, or D load → RD.
    - D store with wstrb=4'b1111 → WR.
    - D store with wstrb=0 → DONE, with no chip access.
    - Any other D store → RMW_RD.
  - RD: mem_en=1, mem_rw=0; next edge captures mem_rdata into the granted rdata → DONE.
  - RMW_RD: same chip read; next edge captures the old word → MERGE.
  - MERGE: per lane k, merged[8k+7:8k] = wstrb[k] ? wdata lane : old lane. No chip access → WR.
  - WR: mem_en=1, mem_rw=1, mem_wdata=merged or full word → DONE.
  - DONE: granted ack=1 for exactly one cycle, mem_en=0 → IDLE.
- Latency from req sampled to ack high: load/fetch 2 cycles; full store 2; partial store 4.
- Requesters must drop req at the edge ending their ack cycle. A re-asserted req is eligible at the next IDLE edge.
- rdata holds its value until the next completion for the same port. d_rdata is not updated on stores.
- Round-robin: when both requesters are high in IDLE, grant the one not in rr_last. A lone requester is always granted.
- mem_en is high only in RD, RMW_RD and WR. mem_addr is the latched address with [1:0]=0. Address bits [1:0] are ignored.

Optional Feature:
- Macro MEMARB_BOUNDS_CHECK_EN.
- Defined: in IDLE, if latched addr[ADDR_W-1:2]*4 + 3 >= MEM_BYTES, go directly to DONE with err=1, no chip access, rdata unchanged.
- Undefined: i_err and d_err are tied 0 and the address passes through unchecked.

Decomposition:
- Package memarb_pkg: FSM state encoding, grant encoding (GNT_I, GNT_D), WSTRB_FULL=4'b1111, byte-lane merge function.
- Sub-module rr_arbiter_2: two requests in; grant and rr_last register out; advances only on an accepted grant.

Test Plan:
- Store 0xDEADBEEF @0x10 with wstrb=1111, then load @0x10 → mem_en pulses 2 times total; d_ack 2 cycles after each req; d_rdata=0xDEADBEEF.
- Memory 0x11223344 @0x20; store wdata=0x0000AA00, wstrb=0010 → sequence RMW_RD, MERGE, WR, DONE; d_ack 4 cycles after req; readback 0x1122AA44.
- i_req and d_req both high from reset, each re-requesting after ack → grants alternate D, I, D, I.
- Fetch @0x13 → mem_addr=0x10; i_rdata = word @0x10.
- Assert reset during MERGE of store 0xFF, wstrb=0001 @0x0 → no ack, all outputs 0; word @0x0 unchanged on readback.
- MEMARB_BOUNDS_CHECK_EN defined, load @0x80 with MEM_BYTES=128 → d_ack with d_err=1 after 1 cycle, mem_en never high; macro undefined → normal access, d_err=0.
